mult_operand_sequencer: RTL and testbench

// Upstream feeder for the repeated-addition multiplier datapath (regA/regB/regP + adder).

---
 rtl/mult_operand_sequencer_if.sv | 37 +++
 rtl/mult_operand_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mult_operand_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// mult_operand_sequencer_if
// Bundles the signals around the operand sequencer: the operand-pair
// handshake, the operand bus and strobes to the repeated-addition
// datapath, the datapath feedback, and the result handshake.
//   slave  : sequencer view (drives op_ready, bus/strobes, res_*, busy)
//   master : environment view (drives operands, eqz, product_in, res_ready)
// ---------------------------------------------------------------------------
interface mult_operand_sequencer_if #(
  parameter int W = 15
);
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] bus_out;
  logic         ld_a;
  logic         ld_b;
  logic         clr_p;
  logic         eqz;
  logic [W-1:0] product_in;
  logic [W-1:0] res_data;
  logic         res_err;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  modport slave (
    input  op_a, op_b, op_valid, eqz, product_in, res_ready,
    output op_ready, bus_out, ld_a, ld_b, clr_p, res_data, res_err, res_valid, busy
  );

  modport master (
    output op_a, op_b, op_valid, eqz, product_in, res_ready,
    input  op_ready, bus_out, ld_a, ld_b, clr_p, res_data, res_err, res_valid, busy
  );
endinterface

// File: rtl/mult_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mult_operand_sequencer
// Feeds operand pairs to a repeated-addition multiplier datapath
// (regA/regB/regP + adder) over one shared operand bus: A is loaded first,
// then B together with a clear of P. The sequencer then waits for the
// datapath's eqz flag (regB reached zero) and captures P as the product,
// or flags a timeout if eqz never arrives within MAX_CYCLES RUN cycles.
//
// Ports
//   clk, rst : clock (rising edge) and synchronous active-high reset
//   sif      : slave view of mult_operand_sequencer_if
//              op_a/op_b/op_valid/op_ready  operand-pair handshake
//              bus_out/ld_a/ld_b/clr_p      operand bus and strobes
//              eqz/product_in               datapath feedback
//              res_data/res_err/res_valid/res_ready  result handshake
//              busy                         high outside IDLE
//
// Every output is a flop loaded from the next-state decode, so no input
// reaches an output combinationally.
// ---------------------------------------------------------------------------
module mult_operand_sequencer #(
  parameter int W          = 15,
  parameter int MAX_CYCLES = 40000,
  parameter int CNT_W      = 16
) (
  input logic                    clk,
  input logic                    rst,
  mult_operand_sequencer_if.slave sif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  logic [2:0]       state_reg,    state_next;
  logic [W-1:0]     a_reg,        a_next;
  logic [W-1:0]     b_reg,        b_next;
  logic [CNT_W-1:0] cnt_reg,      cnt_next;
  logic [W-1:0]     res_data_reg, res_data_next;
  logic             res_err_reg,  res_err_next;

  // Registered outputs, decoded from the state being entered
  logic [W-1:0]     bus_out_reg,  bus_out_next;
  logic             ld_a_reg;
  logic             ld_b_reg;
  logic             clr_p_reg;
  logic             res_valid_reg;
  logic             op_ready_reg;
  logic             busy_reg;

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    cnt_next      = cnt_reg;
    res_data_next = res_data_reg;
    res_err_next  = res_err_reg;

    case (state_reg)
      IDLE: begin
        // op_ready_reg rather than the state alone, so that the cycle right
        // after reset (op_ready still 0) cannot accept a pair.
        if (sif.op_valid && op_ready_reg) begin
          a_next     = sif.op_a;
          b_next     = sif.op_b;
          state_next = LOAD_A;
        end
      end
      LOAD_A: begin
        state_next = LOAD_B;
      end
      LOAD_B: begin
        if (b_reg == '0) begin
          // Zero multiplier: product is 0 without running the datapath.
          res_data_next = '0;
          res_err_next  = 1'b0;
          state_next    = RESULT;
        end else begin
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        cnt_next = cnt_reg + 1'b1;
        // cnt_reg == 0 marks the first RUN cycle, where eqz still reflects
        // regB from before the load settled and must be ignored.
        if (sif.eqz && (cnt_reg != '0)) begin
          res_data_next = sif.product_in;
          res_err_next  = 1'b0;
          state_next    = RESULT;
        end else if (cnt_reg == CNT_LAST) begin
          res_data_next = sif.product_in;
          res_err_next  = 1'b1;
          state_next    = RESULT;
        end
      end
      RESULT: begin
        if (res_valid_reg && sif.res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    bus_out_next = '0;
    if (state_next == LOAD_A) begin
      bus_out_next = a_next;
    end else if (state_next == LOAD_B) begin
      bus_out_next = b_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      cnt_reg       <= '0;
      res_data_reg  <= '0;
      res_err_reg   <= 1'b0;
      bus_out_reg   <= '0;
      ld_a_reg      <= 1'b0;
      ld_b_reg      <= 1'b0;
      clr_p_reg     <= 1'b0;
      res_valid_reg <= 1'b0;
      op_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      cnt_reg       <= cnt_next;
      res_data_reg  <= res_data_next;
      res_err_reg   <= res_err_next;
      bus_out_reg   <= bus_out_next;
      ld_a_reg      <= (state_next == LOAD_A);
      ld_b_reg      <= (state_next == LOAD_B);
      clr_p_reg     <= (state_next == LOAD_B);
      res_valid_reg <= (state_next == RESULT);
      op_ready_reg  <= (state_next == IDLE);
      busy_reg      <= (state_next != IDLE);
    end
  end

  assign sif.op_ready  = op_ready_reg;
  assign sif.bus_out   = bus_out_reg;
  assign sif.ld_a      = ld_a_reg;
  assign sif.ld_b      = ld_b_reg;
  assign sif.clr_p     = clr_p_reg;
  assign sif.res_data  = res_data_reg;
  assign sif.res_err   = res_err_reg;
  assign sif.res_valid = res_valid_reg;
  assign sif.busy      = busy_reg;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mult_operand_sequencer
// Table-driven bench for mult_operand_sequencer with a small behavioural
// repeated-addition datapath (regA/regB/regP) closing the loop. The DUT is
// built with MAX_CYCLES=8 so the timeout path is reachable quickly.
// Cycle numbering: the accept edge ends cycle 0; outputs are sampled on the
// falling edge of each following cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_operand_sequencer;
  localparam int W = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_operand_sequencer_if #(.W(W)) sif();

  mult_operand_sequencer #(.W(W), .MAX_CYCLES(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  // Datapath model: P += A and B -= 1 each cycle while B != 0.
  // eqz_mode: 0 = real eqz, 1 = eqz forced high, 2 = eqz stuck low.
  logic [W-1:0] dp_a = '0;
  logic [W-1:0] dp_b = '0;
  logic [W-1:0] dp_p = '0;
  int eqz_mode = 0;

  always @(posedge clk) begin
    if (sif.ld_a) dp_a <= sif.bus_out;
    if (sif.ld_b) dp_b <= sif.bus_out;
    else if (dp_b != '0) dp_b <= dp_b - 1'b1;
    if (sif.clr_p) dp_p <= '0;
    else if (dp_b != '0) dp_p <= dp_p + dp_a;
  end

  assign sif.eqz = (eqz_mode == 1) ? 1'b1 : (eqz_mode == 2) ? 1'b0 : (dp_b == '0);
  assign sif.product_in = dp_p;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           eqz_mode;
    int           hold;
    logic [W-1:0] exp_data;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs[11];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!sif.op_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("idle_ready", 32'(sif.op_ready), 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    wait_idle();
    eqz_mode     = v.eqz_mode;
    sif.op_a     = v.a;
    sif.op_b     = v.b;
    sif.op_valid = 1'b1;
    @(negedge clk);                       // cycle 1
    sif.op_valid = 1'b0;
    check("c1_ld_a",     32'(sif.ld_a), 1);
    check("c1_bus",      32'(sif.bus_out), 32'(v.a));
    check("c1_ld_b",     32'(sif.ld_b), 0);
    check("c1_op_ready", 32'(sif.op_ready), 0);
    @(negedge clk);                       // cycle 2
    check("c2_ld_b",  32'(sif.ld_b), 1);
    check("c2_clr_p", 32'(sif.clr_p), 1);
    check("c2_bus",   32'(sif.bus_out), 32'(v.b));
    check("c2_ld_a",  32'(sif.ld_a), 0);
    cyc = 2;
    while (!sif.res_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (sif.ld_a || sif.ld_b || sif.clr_p || sif.bus_out != '0)
        check("run_strobes", 32'({sif.ld_a, sif.ld_b, sif.clr_p, sif.bus_out}), 0);
    end
    check("latency",  32'(cyc), 32'(v.exp_lat));
    check("res_data", 32'(sif.res_data), 32'(v.exp_data));
    check("res_err",  32'(sif.res_err), 32'(v.exp_err));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check("hold_valid",    32'(sif.res_valid), 1);
      check("hold_data",     32'(sif.res_data), 32'(v.exp_data));
      check("hold_err",      32'(sif.res_err), 32'(v.exp_err));
      check("hold_op_ready", 32'(sif.op_ready), 0);
    end
    sif.res_ready = 1'b1;
    @(negedge clk);
    sif.res_ready = 1'b0;
    check("pop_valid",    32'(sif.res_valid), 0);
    check("pop_op_ready", 32'(sif.op_ready), 1);
    check("pop_busy",     32'(sif.busy), 0);
    eqz_mode = 0;
    $display("vec %0d: a=%0d b=%0d -> data=%0d err=%0d latency=%0d", idx, v.a, v.b,
             v.exp_data, v.exp_err, cyc);
  endtask

  initial begin
    int cyc, pop_cyc, lda2, n_lda, overlap, seen;
    vec_t v2;

    // a, b, eqz_mode, hold, exp_data, exp_err, exp_lat
    vecs[0]  = '{15'd3,     15'd4,  0, 0, 15'd12,    1'b0, 8};
    vecs[1]  = '{15'd7,     15'd0,  0, 0, 15'd0,     1'b0, 3};
    vecs[2]  = '{15'd3,     15'd4,  0, 5, 15'd12,    1'b0, 8};
    vecs[3]  = '{15'd1,     15'd1,  0, 0, 15'd1,     1'b0, 5};
    vecs[4]  = '{15'd0,     15'd6,  0, 0, 15'd0,     1'b0, 10};
    vecs[5]  = '{15'd5,     15'd7,  0, 0, 15'd35,    1'b0, 11};
    vecs[6]  = '{15'd5,     15'd8,  0, 0, 15'd35,    1'b1, 11};
    vecs[7]  = '{15'd3,     15'd20, 2, 0, 15'd21,    1'b1, 11};
    vecs[8]  = '{15'd32767, 15'd2,  0, 0, 15'd32766, 1'b0, 6};
    vecs[9]  = '{15'd16384, 15'd2,  0, 0, 15'd0,     1'b0, 6};
    vecs[10] = '{15'd6,     15'd4,  1, 0, 15'd6,     1'b0, 5};

    sif.op_a      = '0;
    sif.op_b      = '0;
    sif.op_valid  = 1'b0;
    sif.res_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_op_ready",  32'(sif.op_ready), 0);
    check("rst_busy",      32'(sif.busy), 0);
    check("rst_res_valid", 32'(sif.res_valid), 0);
    check("rst_bus",       32'(sif.bus_out), 0);
    check("rst_strobes",   32'({sif.ld_a, sif.ld_b, sif.clr_p}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_op_ready", 32'(sif.op_ready), 1);
    $display("reset released: op_ready=%0d", sif.op_ready);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset pulsed in RUN abandons the pair
    wait_idle();
    sif.op_a = 15'd9; sif.op_b = 15'd6; sif.op_valid = 1'b1;
    @(negedge clk);
    sif.op_valid = 1'b0;
    repeat (3) @(negedge clk);            // cycle 4, in RUN
    check("mid_busy", 32'(sif.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy",     32'(sif.busy), 0);
    check("mid_rst_op_ready", 32'(sif.op_ready), 0);
    check("mid_rst_res",      32'({sif.res_valid, sif.res_err, sif.res_data}), 0);
    check("mid_rst_bus",      32'({sif.ld_a, sif.ld_b, sif.clr_p, sif.bus_out}), 0);
    @(negedge clk);
    check("mid_rst_ready_back", 32'(sif.op_ready), 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sif.res_valid || sif.busy) seen++;
    end
    check("mid_rst_no_result", 32'(seen), 0);
    $display("reset in RUN: pair abandoned, activity after reset=%0d", seen);
    v2 = '{15'd2, 15'd5, 0, 0, 15'd10, 1'b0, 9};
    run_vec(11, v2);

    // Back-to-back pairs, op_valid and res_ready held high
    wait_idle();
    sif.op_a = 15'd2; sif.op_b = 15'd1; sif.op_valid = 1'b1; sif.res_ready = 1'b1;
    cyc = 0; pop_cyc = -1; lda2 = -1; n_lda = 0; overlap = 0;
    while (cyc < 60 && lda2 < 0) begin
      @(negedge clk);
      cyc++;
      if (sif.ld_a && sif.ld_b) overlap++;
      if (sif.ld_a) begin
        n_lda++;
        if (n_lda == 2) lda2 = cyc;
      end
      if (sif.res_valid && pop_cyc < 0) pop_cyc = cyc;
    end
    sif.op_valid = 1'b0;
    check("b2b_first_pop", 32'(pop_cyc), 5);
    check("b2b_second_ld_a", 32'(lda2), 7);
    seen = 0;
    cyc = 0;
    while (cyc < 60 && !(sif.op_ready && !sif.busy && seen != 0)) begin
      @(negedge clk);
      cyc++;
      if (sif.ld_a && sif.ld_b) overlap++;
      if (sif.res_valid && seen == 0) begin
        seen = 1;
        check("b2b_res2_data", 32'(sif.res_data), 2);
      end
    end
    check("b2b_res2_seen", 32'(seen), 1);
    check("b2b_overlap", 32'(overlap), 0);
    sif.res_ready = 1'b0;
    $display("back-to-back: pop cycle=%0d second ld_a cycle=%0d", pop_cyc, lda2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
